// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to instruction
// memory, buffers in-order responses and hands {pc, instruction} to decode.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/addr/ready     fetch request channel (addr word aligned)
//   imem_rsp_valid/data           in-order fetch responses
//   redirect_valid/pc             PC redirect from execute (flushes the stage)
//   inst_valid/pc/code/ready      instruction channel towards decode
module inst_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_code,
    input  logic            inst_ready
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Back-to-back redirects can stack several windows of discards.
    localparam int unsigned DROP_W = CNT_W + 2;

    logic [XLEN-1:0]   pc_q;
    logic [CNT_W-1:0]  pending_q;
    logic [DROP_W-1:0] drop_q;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [XLEN-1:0]   pc_mem   [FIFO_DEPTH];
    logic [XLEN-1:0]   code_mem [FIFO_DEPTH];

    logic              credit_ok;
    logic              accept;
    logic              rsp_known;
    logic              rsp_drop;
    logic              rsp_keep;
    logic              push;
    logic              pop;
    logic [XLEN-1:0]   rsp_pc;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_redirect;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request / response / handshake qualification
    always_comb begin
        credit_ok = (({1'b0, pending_q} + {1'b0, count_q}) < (CNT_W + 1)'(FIFO_DEPTH));
        imem_req_valid = !rst && !redirect_valid && credit_ok;
        imem_req_addr  = pc_q;
        accept         = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_known = imem_rsp_valid && ((pending_q != '0) || (drop_q != '0));
        rsp_drop  = rsp_known && (drop_q != '0);
        rsp_keep  = rsp_known && (drop_q == '0);
        push      = rsp_keep && !redirect_valid;
        inst_valid = !rst && (count_q != '0);
        pop        = inst_valid && inst_ready;
        // Oldest outstanding request sits pending_q words behind the PC.
        rsp_pc = pc_q - (XLEN'(pending_q) << 2);
        inst_pc   = inst_valid ? pc_mem[rd_ptr_q]   : '0;
        inst_code = inst_valid ? code_mem[rd_ptr_q] : '0;
    end

    // Discard count after a redirect: everything still outstanding, saturating
    always_comb begin
        drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(pending_q) - (DROP_W + 1)'(rsp_known);
        drop_redirect = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    // PC, credit and FIFO control state
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            pending_q <= '0;
            drop_q    <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else if (redirect_valid) begin
            pc_q      <= redirect_pc & ~XLEN'(3);
            pending_q <= '0;
            drop_q    <= drop_redirect;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            if (accept) begin
                pc_q <= pc_q + XLEN'(4);
            end
            pending_q <= pending_q + CNT_W'(accept) - CNT_W'(rsp_keep);
            drop_q    <= drop_q - DROP_W'(rsp_drop);
            count_q   <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Buffer storage; contents are qualified by count_q so need no reset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr_q]   <= rsp_pc;
            code_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule
